// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port owner: clears every entry after reset or init_start,
// then shares the port between two writeback requesters with round-robin arbitration.
module regfile_wport_arbiter #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_start,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_last_grant;
  logic          r_clr_wr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_grant_id;

  logic [AW-1:0] w_clr_addr;
  logic          w_ready0;
  logic          w_ready1;
  logic          w_xfer;

  // init_start during a clear restarts the sweep at address 0 in the same cycle.
  assign w_clr_addr = init_start ? '0 : r_clr_cnt;
  assign w_xfer     = w_ready0 | w_ready1;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    if (r_state == S_CLEAR) begin
      if (w_clr_addr == LAST_ADDR) begin
        w_state_nxt = S_RUN;
      end
    end else if (init_start) begin
      w_state_nxt = S_CLEAR;
    end else if (req0_valid && req1_valid) begin
      w_ready0 = r_last_grant;
      w_ready1 = ~r_last_grant;
    end else begin
      w_ready0 = req0_valid;
      w_ready1 = req1_valid;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_last_grant <= 1'b1;
      r_clr_wr     <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_grant_id   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_we     <= 1'b0;
      r_clr_wr <= 1'b0;
      if (r_state == S_CLEAR) begin
        r_we      <= 1'b1;
        r_clr_wr  <= 1'b1;
        r_waddr   <= w_clr_addr;
        r_wdata   <= '0;
        r_clr_cnt <= w_clr_addr + 1'b1;
      end else if (init_start) begin
        r_clr_cnt <= '0;
      end else if (w_xfer) begin
        r_we         <= 1'b1;
        r_waddr      <= w_ready1 ? req1_addr : req0_addr;
        r_wdata      <= w_ready1 ? req1_data : req0_data;
        r_grant_id   <= w_ready1;
        r_last_grant <= w_ready1;
      end
    end
  end

  // busy also covers the cycle where the final clear write is still on rf_*.
  assign busy       = (r_state == S_CLEAR) | r_clr_wr;
  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed vector table, clear/reset
// sequences, and a randomized run against a behavioural reference model.
module tb_regfile_wport_arbiter;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;

  logic          clk;
  logic          reset;
  logic          init_start;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          grant_id;

  regfile_wport_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file built from the write port, used as the "read back" view.
  logic [DW-1:0] shadow [NREGS];
  always @(posedge clk) begin
    if (rf_we) shadow[rf_waddr] <= rf_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          gid;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          id;
  } wr_t;

  vec_t vecs [11];
  wr_t  sb [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reference model state for the randomized phase
    bit            m_run;
    bit            m_last;
    int            m_clr_next;
    logic [AW-1:0] m_hold_addr;
    logic [DW-1:0] m_hold_data;
    bit            e_r0, e_r1, e_we, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            wait0, wait1, max_wait;
    wr_t           w;

    // Arbitration table, applied in order from the first RUN cycle (last_grant=1).
    vecs[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0,  1'b1, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'd0,        1'b0, 3'd0, 32'd0,  1'b0, 1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 32'd0,        1'b1, 3'd5, 32'h55, 1'b0, 1'b1, 1'b1, 3'd5, 32'h55,       1'b1};
    vecs[3]  = '{1'b1, 3'd1, 32'd1,        1'b1, 3'd2, 32'd2,  1'b1, 1'b0, 1'b1, 3'd1, 32'd1,        1'b0};
    vecs[4]  = '{1'b1, 3'd1, 32'd1,        1'b1, 3'd2, 32'd2,  1'b0, 1'b1, 1'b1, 3'd2, 32'd2,        1'b1};
    vecs[5]  = '{1'b1, 3'd1, 32'd1,        1'b1, 3'd2, 32'd2,  1'b1, 1'b0, 1'b1, 3'd1, 32'd1,        1'b0};
    vecs[6]  = '{1'b1, 3'd1, 32'd1,        1'b1, 3'd2, 32'd2,  1'b0, 1'b1, 1'b1, 3'd2, 32'd2,        1'b1};
    vecs[7]  = '{1'b0, 3'd0, 32'd0,        1'b1, 3'd7, 32'h77, 1'b0, 1'b1, 1'b1, 3'd7, 32'h77,       1'b1};
    vecs[8]  = '{1'b1, 3'd4, 32'h44,       1'b1, 3'd4, 32'h45, 1'b1, 1'b0, 1'b1, 3'd4, 32'h44,       1'b0};
    vecs[9]  = '{1'b1, 3'd4, 32'h44,       1'b1, 3'd4, 32'h45, 1'b0, 1'b1, 1'b1, 3'd4, 32'h45,       1'b1};
    vecs[10] = '{1'b0, 3'd0, 32'd0,        1'b0, 3'd0, 32'd0,  1'b0, 1'b0, 1'b0, 3'd4, 32'h45,       1'b1};

    reset = 1'b0; init_start = 1'b0;
    req0_valid = 1'b1; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b1; req1_addr = '0; req1_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 1);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    // Clear sweep after reset release
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("clr_busy_start", busy, 1);
    for (int i = 0; i < NREGS; i++) begin
      cycle();
      check("clr_we", rf_we, 1);
      check("clr_waddr", rf_waddr, i);
      check("clr_wdata", rf_wdata, 0);
      check("clr_busy", busy, 1);
    end
    cycle();
    check("post_clr_we", rf_we, 0);
    check("post_clr_busy", busy, 0);

    // Arbitration vector table
    foreach (vecs[k]) begin
      req0_valid = vecs[k].v0; req0_addr = vecs[k].a0; req0_data = vecs[k].d0;
      req1_valid = vecs[k].v1; req1_addr = vecs[k].a1; req1_data = vecs[k].d1;
      #1;
      check($sformatf("vec%0d_ready0", k), req0_ready, vecs[k].r0);
      check($sformatf("vec%0d_ready1", k), req1_ready, vecs[k].r1);
      cycle();
      check($sformatf("vec%0d_we", k), rf_we, vecs[k].we);
      check($sformatf("vec%0d_waddr", k), rf_waddr, vecs[k].wa);
      check($sformatf("vec%0d_wdata", k), rf_wdata, vecs[k].wd);
      check($sformatf("vec%0d_gid", k), grant_id, vecs[k].gid);
      check($sformatf("vec%0d_busy", k), busy, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();
    check("readback_r3", shadow[3], 32'hDEADBEEF);

    // init_start wins over a same-cycle request, then the request goes first in RUN
    init_start = 1'b1;
    req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 32'h66;
    #1;
    check("init_ready1", req1_ready, 0);
    check("init_ready0", req0_ready, 0);
    cycle();
    init_start = 1'b0;
    check("init_we", rf_we, 0);
    check("init_busy", busy, 1);
    for (int i = 0; i < NREGS; i++) begin
      check("init_clr_ready1", req1_ready, 0);
      cycle();
      check("init_clr_we", rf_we, 1);
      check("init_clr_waddr", rf_waddr, i);
      check("init_clr_wdata", rf_wdata, 0);
    end
    check("first_run_ready1", req1_ready, 1);
    cycle();
    req1_valid = 1'b0;
    check("first_run_we", rf_we, 1);
    check("first_run_waddr", rf_waddr, 6);
    check("first_run_wdata", rf_wdata, 32'h66);
    check("first_run_gid", grant_id, 1);
    check("first_run_busy", busy, 0);

    // Asynchronous reset in the middle of a clear
    init_start = 1'b1;
    cycle();
    init_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("midclr_waddr", rf_waddr, i);
    end
    reset = 1'b0;
    #1;
    check("async_rst_we", rf_we, 0);
    check("async_rst_busy", busy, 1);
    check("async_rst_waddr", rf_waddr, 0);
    cycle();
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      cycle();
      check("reclr_we", rf_we, 1);
      check("reclr_waddr", rf_waddr, i);
    end

    // Randomized phase against the reference model
    m_run = 1'b1; m_last = 1'b1; m_clr_next = 0;
    m_hold_addr = 3'(NREGS - 1); m_hold_data = '0;
    wait0 = 0; wait1 = 0; max_wait = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1'b1; req0_addr = 3'($urandom_range(7)); req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1'b1; req1_addr = 3'($urandom_range(7)); req1_data = $urandom;
      end
      init_start = ($urandom_range(99) == 0);
      #1;

      e_r0 = 1'b0; e_r1 = 1'b0;
      if (m_run && !init_start) begin
        if (req0_valid && req1_valid) begin
          e_r0 = (m_last == 1'b1);
          e_r1 = !e_r0;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      check("rnd_ready0", req0_ready, e_r0);
      check("rnd_ready1", req1_ready, e_r1);
      check("rnd_one_ready", req0_ready & req1_ready, 0);

      if (m_run && !init_start) begin
        wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
        wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
        if (wait0 > max_wait) max_wait = wait0;
        if (wait1 > max_wait) max_wait = wait1;
      end else begin
        wait0 = 0; wait1 = 0;
      end

      if (!m_run) begin
        e_addr = init_start ? '0 : 3'(m_clr_next);
        e_data = '0; e_we = 1'b1; e_busy = 1'b1;
        m_clr_next = int'(e_addr) + 1;
        if (int'(e_addr) == NREGS - 1) m_run = 1'b1;
        m_hold_addr = e_addr; m_hold_data = '0;
      end else if (init_start) begin
        m_run = 1'b0; m_clr_next = 0;
        e_we = 1'b0; e_busy = 1'b1;
        e_addr = m_hold_addr; e_data = m_hold_data;
      end else if (e_r0 || e_r1) begin
        w.a = e_r1 ? req1_addr : req0_addr;
        w.d = e_r1 ? req1_data : req0_data;
        w.id = e_r1;
        sb.push_back(w);
        m_last = e_r1;
        m_hold_addr = w.a; m_hold_data = w.d;
        e_we = 1'b1; e_busy = 1'b0;
        e_addr = w.a; e_data = w.d;
      end else begin
        e_we = 1'b0; e_busy = 1'b0;
        e_addr = m_hold_addr; e_data = m_hold_data;
      end

      cycle();
      check("rnd_we", rf_we, e_we);
      check("rnd_busy", busy, e_busy);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("rnd_sb_waddr", rf_waddr, w.a);
        check("rnd_sb_wdata", rf_wdata, w.d);
        check("rnd_sb_gid", grant_id, w.id);
      end else begin
        check("rnd_hold_waddr", rf_waddr, e_addr);
        check("rnd_hold_wdata", rf_wdata, e_data);
      end

      if (e_r0) req0_valid = 1'b0;
      if (e_r1) req1_valid = 1'b0;
    end
    check("rnd_max_wait", max_wait, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
